// File: rtl/conv_window_gen_pkg.sv
// Shared defaults and FSM encoding for the 3x3 window generator.
package conv_window_gen_pkg;

  localparam int PIXEL_DATA_SIZE = 8;
  localparam int IMG_W_DEF       = 8;
  localparam int IMG_H_DEF       = 8;

  // state    | meaning
  // S_IDLE   | no pixel of the current frame accepted yet
  // S_FILL   | filling line buffers, no complete window yet
  // S_STREAM | every accept at row>=2, col>=2 emits a window
  // S_DRAIN  | last pixel taken, waiting for the final window to be consumed
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

endpackage

// File: rtl/conv_window_gen_line_buf.sv
// One-line pixel delay: dout is the pixel written DEPTH enables earlier.
module conv_window_gen_line_buf
  import conv_window_gen_pkg::*;
#(
  parameter int DATA_W = PIXEL_DATA_SIZE,
  parameter int DEPTH  = IMG_W_DEF
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] din,
  output logic signed [DATA_W-1:0] dout
);

  logic signed [DATA_W-1:0] mem_q [DEPTH];
  logic signed [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (en) begin
      mem_d[0] = din;
      for (int i = 1; i < DEPTH; i++) mem_d[i] = mem_q[i-1];
    end
  end

  // Storage is deliberately unreset; it is always refilled before use.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream in, every valid 3x3 window out (row-major win0..win8).
module conv_window_gen
  import conv_window_gen_pkg::*;
#(
  parameter int DATA_W = PIXEL_DATA_SIZE,
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_pix,
  output logic                     win_valid,
  input  logic                     win_ready,
  output logic signed [DATA_W-1:0] win0,
  output logic signed [DATA_W-1:0] win1,
  output logic signed [DATA_W-1:0] win2,
  output logic signed [DATA_W-1:0] win3,
  output logic signed [DATA_W-1:0] win4,
  output logic signed [DATA_W-1:0] win5,
  output logic signed [DATA_W-1:0] win6,
  output logic signed [DATA_W-1:0] win7,
  output logic signed [DATA_W-1:0] win8,
  output logic                     frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic win_valid_q, win_valid_d;
  logic signed [DATA_W-1:0] hist_q [6];
  logic signed [DATA_W-1:0] hist_d [6];
  logic signed [DATA_W-1:0] win_q  [9];
  logic signed [DATA_W-1:0] win_d  [9];
  logic signed [DATA_W-1:0] nw     [9];
  logic signed [DATA_W-1:0] tap0, tap1;
  logic accept, consume, emit, last_pix;

  assign in_ready = (state_q != S_DRAIN) && (!win_valid_q || win_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = win_valid_q && win_ready;
  assign emit     = accept && (row_q >= ROW_TWO) && (col_q >= COL_TWO);
  assign last_pix = (row_q == ROW_LAST) && (col_q == COL_LAST);

  conv_window_gen_line_buf #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_line0 (
    .clk  (clk),
    .en   (accept),
    .din  (in_pix),
    .dout (tap0)
  );

  conv_window_gen_line_buf #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_line1 (
    .clk  (clk),
    .en   (accept),
    .din  (tap0),
    .dout (tap1)
  );

  // hist holds the two rightmost window columns; the leftmost is never needed again.
  always_comb begin
    nw[0] = hist_q[0]; nw[1] = hist_q[1]; nw[2] = tap1;
    nw[3] = hist_q[2]; nw[4] = hist_q[3]; nw[5] = tap0;
    nw[6] = hist_q[4]; nw[7] = hist_q[5]; nw[8] = in_pix;
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    hist_d      = hist_q;
    win_d       = win_q;
    win_valid_d = win_valid_q;

    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      for (int i = 0; i < 3; i++) begin
        hist_d[2*i]   = nw[3*i+1];
        hist_d[2*i+1] = nw[3*i+2];
      end
    end

    // A load in the same cycle as a consume takes priority.
    if (emit) begin
      win_d       = nw;
      win_valid_d = 1'b1;
    end else if (consume) begin
      for (int i = 0; i < 9; i++) win_d[i] = '0;
      win_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE:   if (accept) state_d = S_FILL;
      S_FILL:   if (accept && row_q == ROW_TWO && col_q == COL_TWO) state_d = S_STREAM;
      S_STREAM: if (accept && last_pix) state_d = S_DRAIN;
      S_DRAIN:  if (consume) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      for (int i = 0; i < 6; i++) hist_q[i] <= '0;
      for (int i = 0; i < 9; i++) win_q[i]  <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      hist_q      <= hist_d;
      win_q       <= win_d;
    end
  end

  assign win_valid  = win_valid_q;
  assign frame_done = (state_q == S_DRAIN) && consume;
  assign win0 = win_q[0];
  assign win1 = win_q[1];
  assign win2 = win_q[2];
  assign win3 = win_q[3];
  assign win4 = win_q[4];
  assign win5 = win_q[5];
  assign win6 = win_q[6];
  assign win7 = win_q[7];
  assign win8 = win_q[8];

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Upstream feeder for the 3x3 convolution stage.
- Accepts a raster-order pixel stream (row-major, one pixel per handshake) of a fixed-size feature map and buffers two full lines plus a 3x3 shift window.
- Emits every valid (no-padding) 3x3 window as nine parallel signed pixels, in exactly the order the convolution stage's feature-map inputs 0..8 expect.
- Its output strobe drives the convolution stage's feature-map write enable.

Parameters:
- DATA_W, 8, pixel width in bits (signed); equals the codebase Pixel_DataSize.
- IMG_W, 8, feature-map width in pixels (>=3).
- IMG_H, 8, feature-map height in pixels (>=3).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  pixel on in_pix is offered.
- in_ready  out  1  block can accept a pixel this cycle.
- in_pix  in  DATA_W  signed input pixel, raster order.
- win_valid  out  1  win0..win8 hold a valid window; drives the convolution stage write enable.
- win_ready  in  1  consumer takes the window this cycle. Tie high if the consumer never stalls.
- win0..win8  out  DATA_W each  signed window, row-major: win0 = (r-2,c-2), win1 = (r-2,c-1), win2 = (r-2,c), win3 = (r-1,c-2), ..., win8 = (r,c).
- frame_done  out  1  one-cycle pulse when the last window of a frame is consumed.

Behaviour:
- Reset (rst low, asynchronous):
  - win_valid=0, frame_done=0, win0..win8=0, in_ready=1 after release.
  - col/row counters=0, FSM=S_IDLE.
  - Line-buffer storage is not reset. It is never visible, because windows are only emitted after refill.
- Handshake:
  - A pixel is accepted when in_valid && in_ready.
  - A window is consumed when win_valid && win_ready.
  - in_ready = !win_valid || win_ready. The output register is single-entry, and a pixel is accepted only if any window it completes can be stored.
  - Valid-in must not depend on in_ready.
- Counters:
  - col counts 0..IMG_W-1 and wraps to 0 while incrementing row.
  - row counts 0..IMG_H-1 and wraps to 0 at end of frame.
  - Counters advance only on an accepted pixel.
- Window shift:
  - On each accepted pixel, the 3x3 window shifts left one column.
  - The new right column is {line1 tap, line0 tap, in_pix}: top = pixel two rows up, middle = one row up.
  - Both line buffers shift by one entry.
- Emission:
  - An accepted pixel with row>=2 and col>=2 loads win0..win8 and sets win_valid on the next clock edge (latency 1 cycle).
  - Windows straddling a row wrap (col<2) are never emitted.
  - Windows per frame: (IMG_W-2)*(IMG_H-2).
- win_valid and win0..win8 hold stable until consumed. They clear on consumption unless a new window loads in the same cycle; load wins.
- FSM states:
  - S_IDLE: no pixel of the current frame accepted. Goes to S_FILL on first accept.
  - S_FILL: row<2, or row==2 && col<2. Goes to S_STREAM on accepting (2,2).
  - S_STREAM: emitting windows. On accepting (IMG_H-1, IMG_W-1), goes to S_DRAIN, and in_ready is forced 0.
  - S_DRAIN: waits for the final window to be consumed. That cycle asserts frame_done for one cycle, then goes to S_IDLE and in_ready returns per the rule above.
- Back-to-back frames: no pixel of frame N+1 is accepted until frame_done of frame N.
- Reset mid-frame: all windows in flight are discarded and the next accepted pixel is treated as (0,0).
- No arithmetic is performed; values pass unchanged (sign preserved).

Decomposition:
- Shared package/header holds:
  - the DATA_W default (Pixel_DataSize);
  - default IMG_W/IMG_H;
  - FSM state encodings S_IDLE/S_FILL/S_STREAM/S_DRAIN (2-bit).
- One natural sub-module: line_buf, a DATA_W x IMG_W shift-register delay line with an enable. It is instantiated twice in series (line0 feeds line1).

Test Plan:
- 5x5 frame (IMG_W=IMG_H=5), pix = row*5+col, in_valid=1 and win_ready=1 continuously:
  - first win_valid is 1 cycle after the 13th accept, with win = {0,1,2,5,6,7,10,11,12};
  - last window is {12,13,14,17,18,19,22,23,24};
  - exactly 9 windows; frame_done pulses once, coincident with consumption of the last window.
- Backpressure: win_ready=0 for 4 cycles after the first window:
  - in_ready=0 throughout, and win0..win8 hold {0,1,2,5,6,7,10,11,12};
  - no pixel is lost; the window sequence is identical to the first test.
- Signed data: all pixels 8'sh80 except (1,1)=8'sh7F -> the first window shows win4=8'sh7F and all others 8'sh80 unchanged.
- Gapped input: in_valid toggles every other cycle -> the same 9 windows in the same order, each 1 cycle after its completing accept.
- Reset mid-frame: assert rst low after 15 accepts, then release and send a full fresh frame -> no window from the aborted frame appears, and the fresh frame yields exactly the first test's sequence.
- Back-to-back frames with win_ready=1: in_ready is 0 during S_DRAIN, and frame 2's first window matches frame 1's.
